// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline constants: datapath width, register address width, write-back select codes.
package rv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_WORD = 2'b01;
    localparam logic [1:0] WB_SEL_HALF = 2'b10;
    localparam logic [1:0] WB_SEL_BYTE = 2'b11;
endpackage

// File: rtl/regfile_wb_if.sv
// MA/WB write-back bus plus the two decode read ports of the register file.
interface regfile_wb_if;
    import rv_pkg::*;

    logic [XLEN-1:0]   data_in;
    logic [XLEN-1:0]   busc_in;
    logic              write_ena_in;
    logic [REG_AW-1:0] rd_in;
    logic [1:0]        wrn_in;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;

    modport master (
        output data_in, busc_in, write_ena_in, rd_in, wrn_in, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data
    );

    modport slave (
        input  data_in, busc_in, write_ena_in, rd_in, wrn_in, rs1_addr, rs2_addr,
        output rs1_data, rs2_data
    );
endinterface

// File: rtl/regfile_wb_select.sv
// Write-back value mux: ALU bus or load data, with half/byte sign extension.
// Purely combinational, zero latency; no flow control.
module regfile_wb_select
    import rv_pkg::*;
(
    input  logic [1:0]      wrn,
    input  logic [XLEN-1:0] data,
    input  logic [XLEN-1:0] busc,
    output logic [XLEN-1:0] value
);

    always_comb begin
        value = busc;
        unique case (wrn)
            WB_SEL_ALU:  value = busc;
            WB_SEL_WORD: value = data;
            WB_SEL_HALF: value = {{(XLEN-16){data[15]}}, data[15:0]};
            WB_SEL_BYTE: value = {{(XLEN-8){data[7]}}, data[7:0]};
            default:     value = busc;
        endcase
    end

endmodule

// File: rtl/regfile_wb.sv
// 32x32 register file commit stage with bypassed combinational reads and a retire counter.
// Commit on the rising edge, reads zero-latency; always accepts, no backpressure.
module regfile_wb
    import rv_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_wb_if.slave     bus,
    output logic [XLEN-1:0] wb_value,
    output logic [XLEN-1:0] wb_count
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] cnt_q;
    logic            commit;

    regfile_wb_select u_select (
        .wrn   (bus.wrn_in),
        .data  (bus.data_in),
        .busc  (bus.busc_in),
        .value (wb_value)
    );

    assign commit = bus.write_ena_in && (bus.rd_in != '0);

    // Entry 0 is reset and never written, so it always reads back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[bus.rd_in] <= wb_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (commit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign wb_count = cnt_q;

    // Bypass is gated by rst_n so both ports read zero while reset is held.
    always_comb begin
        bus.rs1_data = '0;
        if (bus.rs1_addr != '0) begin
            if (rst_n && bus.write_ena_in && (bus.rd_in == bus.rs1_addr)) begin
                bus.rs1_data = wb_value;
            end else begin
                bus.rs1_data = regs_q[bus.rs1_addr];
            end
        end
    end

    always_comb begin
        bus.rs2_data = '0;
        if (bus.rs2_addr != '0) begin
            if (rst_n && bus.write_ena_in && (bus.rd_in == bus.rs2_addr)) begin
                bus.rs2_data = wb_value;
            end else begin
                bus.rs2_data = regs_q[bus.rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: expectations queued as stimulus is driven, popped at each check.
module tb_regfile_wb;
    import rv_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] wb_value;
    logic [XLEN-1:0] wb_count;

    int errors = 0;
    int checks = 0;
    logic [XLEN-1:0] exp_q [$];

    regfile_wb_if bus ();

    regfile_wb #(.NREGS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .wb_value (wb_value),
        .wb_count (wb_count)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [XLEN-1:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs);
        logic [XLEN-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [1:0] wrn,
                         input logic [31:0] busc, input logic [31:0] data,
                         input logic [4:0] a1, input logic [4:0] a2);
        bus.write_ena_in = we;
        bus.rd_in        = rd;
        bus.wrn_in       = wrn;
        bus.busc_in      = busc;
        bus.data_in      = data;
        bus.rs1_addr     = a1;
        bus.rs2_addr     = a2;
    endtask

    // Drive at the falling edge, sample 2ns later, well away from either edge.
    task automatic step_drive(input logic we, input logic [4:0] rd, input logic [1:0] wrn,
                              input logic [31:0] busc, input logic [31:0] data,
                              input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        drive(we, rd, wrn, busc, data, a1, a2);
        #2;
    endtask

    initial begin
        drive(1'b0, 5'd0, WB_SEL_ALU, 32'h0, 32'h0, 5'd0, 5'd0);

        // Reset state
        #2;
        push(32'h0); chk("reset_rs1", bus.rs1_data);
        push(32'h0); chk("reset_rs2", bus.rs2_data);
        push(32'h0); chk("reset_count", wb_count);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU commit to x7 with same-cycle bypass, then storage read
        step_drive(1'b1, 5'd7, WB_SEL_ALU, 32'hDEADBEEF, 32'h0, 5'd7, 5'd0);
        push(32'hDEADBEEF); chk("alu_wb_value", wb_value);
        push(32'hDEADBEEF); chk("x7_bypass", bus.rs1_data);
        step_drive(1'b0, 5'd0, WB_SEL_ALU, 32'h0, 32'h0, 5'd7, 5'd0);
        push(32'hDEADBEEF); chk("x7_storage", bus.rs1_data);
        push(32'd1);        chk("count_after_x7", wb_count);

        // Load extension variants
        step_drive(1'b1, 5'd3, WB_SEL_HALF, 32'h0, 32'h000080FF, 5'd0, 5'd0);
        push(32'hFFFF80FF); chk("half_wb_value", wb_value);
        step_drive(1'b1, 5'd4, WB_SEL_BYTE, 32'h0, 32'h000080FF, 5'd0, 5'd0);
        push(32'hFFFFFFFF); chk("byte_wb_value", wb_value);
        step_drive(1'b1, 5'd6, WB_SEL_WORD, 32'h0, 32'h000080FF, 5'd0, 5'd0);
        push(32'h000080FF); chk("word_wb_value", wb_value);
        step_drive(1'b0, 5'd0, WB_SEL_ALU, 32'h0, 32'h0, 5'd3, 5'd4);
        push(32'hFFFF80FF); chk("x3_half", bus.rs1_data);
        push(32'hFFFFFFFF); chk("x4_byte", bus.rs2_data);
        step_drive(1'b0, 5'd0, WB_SEL_ALU, 32'h0, 32'h0, 5'd6, 5'd7);
        push(32'h000080FF); chk("x6_word", bus.rs1_data);
        push(32'hDEADBEEF); chk("x7_retained", bus.rs2_data);
        push(32'd4);        chk("count_after_ext", wb_count);

        // x0 write attempt: no bypass, no storage, no count
        step_drive(1'b1, 5'd0, WB_SEL_ALU, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
        push(32'h0); chk("x0_rs1_same", bus.rs1_data);
        push(32'h0); chk("x0_rs2_same", bus.rs2_data);
        step_drive(1'b0, 5'd0, WB_SEL_ALU, 32'h0, 32'h0, 5'd0, 5'd0);
        push(32'h0); chk("x0_rs1_after", bus.rs1_data);
        push(32'd4); chk("x0_count", wb_count);

        // Bubble to x9 changes nothing
        step_drive(1'b0, 5'd9, WB_SEL_ALU, 32'h12345678, 32'h0, 5'd9, 5'd9);
        push(32'h0); chk("bubble_no_bypass", bus.rs1_data);
        step_drive(1'b0, 5'd0, WB_SEL_ALU, 32'h0, 32'h0, 5'd9, 5'd0);
        push(32'h0); chk("bubble_x9", bus.rs1_data);
        push(32'd4); chk("bubble_count", wb_count);

        // Dual bypass
        step_drive(1'b1, 5'd9, WB_SEL_ALU, 32'hA5A5A5A5, 32'h0, 5'd9, 5'd9);
        push(32'hA5A5A5A5); chk("dual_rs1", bus.rs1_data);
        push(32'hA5A5A5A5); chk("dual_rs2", bus.rs2_data);
        step_drive(1'b0, 5'd0, WB_SEL_ALU, 32'h0, 32'h0, 5'd9, 5'd7);
        push(32'hA5A5A5A5); chk("x9_storage", bus.rs1_data);
        push(32'd5);        chk("count_after_x9", wb_count);

        // Write x5 then assert reset mid-cycle with a pending bypass on x5
        step_drive(1'b1, 5'd5, WB_SEL_ALU, 32'h12345678, 32'h0, 5'd0, 5'd0);
        step_drive(1'b0, 5'd0, WB_SEL_ALU, 32'h0, 32'h0, 5'd5, 5'd0);
        push(32'h12345678); chk("x5_storage", bus.rs1_data);
        push(32'd6);        chk("count_before_rst", wb_count);
        drive(1'b1, 5'd5, WB_SEL_ALU, 32'h12345678, 32'h0, 5'd5, 5'd7);
        rst_n = 1'b0;
        #1;
        push(32'h0);        chk("rst_x5", bus.rs1_data);
        push(32'h0);        chk("rst_x7", bus.rs2_data);
        push(32'h0);        chk("rst_count", wb_count);
        push(32'h12345678); chk("rst_wb_value", wb_value);

        // First commit after release lands on the first rising edge
        step_drive(1'b1, 5'd5, WB_SEL_ALU, 32'h0BADF00D, 32'h0, 5'd5, 5'd0);
        rst_n = 1'b1;
        #1;
        push(32'h0BADF00D); chk("post_rst_bypass", bus.rs1_data);
        step_drive(1'b0, 5'd0, WB_SEL_ALU, 32'h0, 32'h0, 5'd5, 5'd7);
        push(32'h0BADF00D); chk("post_rst_x5", bus.rs1_data);
        push(32'h0);        chk("post_rst_x7", bus.rs2_data);
        push(32'd1);        chk("post_rst_count", wb_count);

        // Counter wrap via backdoor preload
        @(negedge clk);
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        push(32'hFFFFFFFF); chk("preload_count", wb_count);
        release dut.cnt_q;
        drive(1'b1, 5'd10, WB_SEL_ALU, 32'h1, 32'h0, 5'd0, 5'd0);
        step_drive(1'b0, 5'd0, WB_SEL_ALU, 32'h0, 32'h0, 5'd10, 5'd0);
        push(32'h0); chk("wrap_count", wb_count);
        push(32'h1); chk("wrap_x10", bus.rs1_data);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
